// File: rtl/dense_pkg.sv
// Shared types and helpers for the dense (fully-connected) datapath stages.
package dense_pkg;

  localparam logic [1:0] ACT_NONE = 2'd0;
  localparam logic [1:0] ACT_RELU = 2'd1;
  localparam logic [1:0] ACT_HSIG = 2'd2;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DRAIN = 2'd2
  } state_e;

  // Widest value the saturate helper handles; accumulators must fit in this.
  localparam int SAT_W = 64;

  function automatic logic signed [SAT_W-1:0] sat_s(input logic signed [SAT_W-1:0] v,
                                                    input int unsigned w);
    logic signed [SAT_W-1:0] hi;
    logic signed [SAT_W-1:0] lo;
    hi = (SAT_W'(1) << (w - 1)) - SAT_W'(1);
    lo = ~hi;
    if (v > hi) return hi;
    if (v < lo) return lo;
    return v;
  endfunction

endpackage

// File: rtl/dense_post_proc.sv
// Post-accumulation stage: fixed-point rescale with saturation, bias add and
// run-time selectable activation. Purely combinational.
module dense_post_proc
  import dense_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int FRAC_W = 8,
  parameter int ACC_W  = 42
) (
  input  logic signed [ACC_W-1:0]  acc,
  input  logic signed [DATA_W-1:0] bias,
  input  logic [1:0]               act_mode,
  output logic signed [DATA_W-1:0] result
);

  localparam logic signed [DATA_W:0] HALF = (DATA_W+1)'(2 ** (FRAC_W - 1));
  localparam logic signed [DATA_W:0] ONE  = (DATA_W+1)'(2 ** FRAC_W);

  logic signed [ACC_W-1:0]  acc_sh;
  logic signed [DATA_W-1:0] x;
  logic signed [DATA_W-1:0] y;
  logic signed [DATA_W-1:0] y_q2;
  logic signed [DATA_W:0]   sum;
  logic signed [DATA_W:0]   hs;

  // Arithmetic shift floors toward -inf, matching the fixed-point rescale.
  assign acc_sh = acc >>> FRAC_W;
  assign x      = DATA_W'(sat_s(SAT_W'(acc_sh), DATA_W));
  assign sum    = {x[DATA_W-1], x} + {bias[DATA_W-1], bias};
  assign y      = DATA_W'(sat_s(SAT_W'(sum), DATA_W));
  assign y_q2   = y >>> 2;
  assign hs     = {y_q2[DATA_W-1], y_q2} + HALF;

  always_comb begin
    result = y;
    case (act_mode)
      ACT_RELU: begin
        if (y[DATA_W-1]) result = '0;
      end
      ACT_HSIG: begin
        if (hs[DATA_W])   result = '0;
        else if (hs > ONE) result = DATA_W'(ONE);
        else               result = hs[DATA_W-1:0];
      end
      default: result = y;
    endcase
  end

endmodule

// File: rtl/dense_layer_param.sv
// Parametrised fully-connected layer: one activation per beat into NUM_OUT
// parallel MACs, then serial drain of bias-added, saturated, activated results.
//
//   state | meaning
//   IDLE  | waiting for an accepted frame_start_in
//   ACCUM | accepting samples and accumulating; end_pend = last sample seen,
//         | waiting one cycle for the final MAC
//   DRAIN | presenting NUM_OUT results under out_valid/out_ready
module dense_layer_param
  import dense_pkg::*;
#(
  parameter int DATA_W  = 16,
  parameter int FRAC_W  = 8,
  parameter int NUM_OUT = 120,
  parameter int IN_LEN  = 980,
  parameter int ADDR_W  = 10
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [1:0]                act_mode,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic                      frame_start_in,
  input  logic                      frame_end_in,
  input  logic signed [DATA_W-1:0]  dense_input,
  output logic [ADDR_W-1:0]         w_addr,
  input  logic [NUM_OUT*DATA_W-1:0] w_data,
  input  logic [NUM_OUT*DATA_W-1:0] bias_data,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic signed [DATA_W-1:0]  dense_out,
  output logic                      frame_start_out,
  output logic                      frame_end_out,
  output logic                      len_err
);

  localparam int ACC_W = 2 * DATA_W + $clog2(IN_LEN);
  localparam int CNT_W = $clog2(IN_LEN + 1) + 1;
  localparam int IDX_W = (NUM_OUT > 1) ? $clog2(NUM_OUT) : 1;

  localparam logic [CNT_W-1:0] LEN_C    = CNT_W'(IN_LEN);
  localparam logic [CNT_W-1:0] LAST_C   = CNT_W'(IN_LEN - 1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_OUT - 1);

  state_e                   state;
  logic [CNT_W-1:0]         cnt;
  logic                     end_pend;
  logic [1:0]               mode_q;
  logic signed [DATA_W-1:0] smp_q;
  logic                     mac_en;
  logic [IDX_W-1:0]         idx;
  logic                     issue_done;

  logic signed [ACC_W-1:0]    acc  [NUM_OUT];
  logic signed [2*DATA_W-1:0] prod [NUM_OUT];

  logic                     accept;
  logic                     start_acc;
  logic                     frm_acc;
  logic [CNT_W-1:0]         samp_idx;
  logic [CNT_W-1:0]         next_cnt;
  logic                     out_load;
  logic signed [DATA_W-1:0] bias_sel;
  logic signed [DATA_W-1:0] pp_result;

  assign in_ready  = (state == IDLE) || ((state == ACCUM) && !end_pend);
  assign accept    = in_valid && in_ready;
  assign start_acc = accept && frame_start_in;
  assign frm_acc   = accept && (frame_start_in || (state == ACCUM));
  assign samp_idx  = start_acc ? '0 : cnt;
  // Counter saturates at IN_LEN so over-long frames neither wrap nor MAC.
  assign next_cnt  = (samp_idx == LEN_C) ? LEN_C : samp_idx + 1'b1;
  assign w_addr    = (samp_idx >= LEN_C) ? ADDR_W'(IN_LEN - 1) : ADDR_W'(samp_idx);
  assign out_load  = !out_valid || out_ready;

  always_comb begin
    for (int k = 0; k < NUM_OUT; k++) begin
      prod[k] = smp_q * $signed(w_data[k*DATA_W +: DATA_W]);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < NUM_OUT; k++) acc[k] <= '0;
    end else if (start_acc) begin
      for (int k = 0; k < NUM_OUT; k++) acc[k] <= '0;
    end else if (mac_en) begin
      for (int k = 0; k < NUM_OUT; k++) acc[k] <= acc[k] + ACC_W'(prod[k]);
    end
  end

  assign bias_sel = $signed(bias_data[idx*DATA_W +: DATA_W]);

  dense_post_proc #(
    .DATA_W(DATA_W),
    .FRAC_W(FRAC_W),
    .ACC_W (ACC_W)
  ) u_post (
    .acc     (acc[idx]),
    .bias    (bias_sel),
    .act_mode(mode_q),
    .result  (pp_result)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state           <= IDLE;
      cnt             <= '0;
      end_pend        <= 1'b0;
      mode_q          <= ACT_NONE;
      smp_q           <= '0;
      mac_en          <= 1'b0;
      idx             <= '0;
      issue_done      <= 1'b0;
      out_valid       <= 1'b0;
      dense_out       <= '0;
      frame_start_out <= 1'b0;
      frame_end_out   <= 1'b0;
      len_err         <= 1'b0;
    end else begin
      mac_en <= frm_acc && (samp_idx < LEN_C);
      if (frm_acc) begin
        smp_q <= dense_input;
        cnt   <= next_cnt;
        if (frame_start_in) begin
          state   <= ACCUM;
          mode_q  <= act_mode;
          len_err <= 1'b0;
        end
        if (frame_end_in) begin
          end_pend <= 1'b1;
          len_err  <= (samp_idx != LAST_C);
        end
      end

      case (state)
        IDLE: ;
        ACCUM: begin
          if (end_pend) begin
            state      <= DRAIN;
            end_pend   <= 1'b0;
            idx        <= '0;
            issue_done <= 1'b0;
          end
        end
        DRAIN: begin
          if (out_load) begin
            if (!issue_done) begin
              out_valid       <= 1'b1;
              dense_out       <= pp_result;
              frame_start_out <= (idx == '0);
              frame_end_out   <= (idx == LAST_IDX);
              if (idx == LAST_IDX) issue_done <= 1'b1;
              else                 idx        <= idx + 1'b1;
            end else begin
              // Last beat has just handshaken.
              out_valid       <= 1'b0;
              frame_start_out <= 1'b0;
              frame_end_out   <= 1'b0;
              cnt             <= '0;
              state           <= IDLE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
